mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, memory word-address width (1024 words).
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles (m_en edge to valid m_rdata); legal range 1..8.
REQ-004 SHALL have parameter STARVE_MAX, default 2, max consecutive data grants while fetch waits; legal range 1..15.
REQ-005 SHALL have ports:
  clk1  in  1  sole clock, all state on rising edge;
  rst  in  1  asynchronous, active-high reset;
  if_req  in  1  fetch request, held with if_addr until if_valid;
  if_addr  in  AW  fetch word address;
  if_gnt  out  1  fetch access issued this cycle;
  if_valid  out  1  one-cycle pulse, if_rdata valid;
  if_rdata  out  DW  fetched word;
  d_req  in  1  data request, held with d_we/d_addr/d_wdata until d_valid;
  d_we  in  1  1=store, 0=load;
  d_addr  in  AW  data word address;
  d_wdata  in  DW  store data;
  d_gnt  out  1  data access issued this cycle;
  d_valid  out  1  one-cycle pulse, load data valid or store done;
  d_rdata  out  DW  loaded word;
  m_en  out  1  memory port enable;
  m_we  out  1  memory write enable;
  m_addr  out  AW  memory address;
  m_wdata  out  DW  memory write data;
  m_rdata  in  DW  memory read data;
  busy  out  1  state is not IDLE.

Function
REQ-006 SHALL share one single-port synchronous memory between fetch and data requesters, one access in flight at a time.
REQ-007 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-008 IDLE: no request -> IDLE; any request -> ACCESS, owner and address/we/wdata latched at that edge.
REQ-009 Arbitration: data wins over fetch, except fetch wins when starve counter equals STARVE_MAX and both request.
REQ-010 Starve counter SHALL increment on each data grant while if_req=1, clear on each fetch grant, saturate at STARVE_MAX.
REQ-011 ACCESS (exactly one cycle): m_en=1, m_we=latched we, m_addr/m_wdata=latched values, owner gnt=1; -> WAIT.
REQ-012 WAIT SHALL last MEM_LAT cycles; m_rdata captured into the owner rdata register at the last WAIT edge; -> RESP.
REQ-013 RESP (one cycle): owner valid=1; -> IDLE.
REQ-014 Latency: request sampled at edge 0 -> gnt in cycle 1 -> valid in cycle 2+MEM_LAT (cycle 3 at MEM_LAT=1).
REQ-015 In all non-ACCESS states m_en=0, m_we=0; gnt of the non-owner SHALL never assert.
REQ-016 Stores SHALL also pass through WAIT/RESP; d_rdata SHALL be left unchanged on stores.
REQ-017 rdata outputs SHALL hold their last captured value until the next capture for that requester.
REQ-018 A request still high in IDLE after its valid SHALL be treated as a new request.
REQ-019 Simultaneous requests with counter below STARVE_MAX: data granted, fetch waits; fetch request SHALL not be lost.
REQ-020 Requests changing or dropping before valid are illegal; behaviour is unspecified.

Reset
REQ-021 rst=1 SHALL immediately force IDLE and: gnts, valids, m_en, m_we, busy = 0; m_addr, m_wdata, rdata outputs, starve counter = 0.
REQ-022 Reset mid-access SHALL abort with no valid pulse; a write already issued in ACCESS is not undone.

Configuration
REQ-023 With ARB_PERF_EN defined: extra output conflict_cnt (16 bits) SHALL count cycles in IDLE with if_req=1 and d_req=1, saturating at 16'hFFFF, reset to 0.
REQ-024 Without ARB_PERF_EN: port and counter absent; all other behaviour identical.

Verification
REQ-025 Fetch only, MEM_LAT=1, if_addr=5, Mem[5]=32'h2801000A -> if_gnt cycle 1, if_valid cycle 3, if_rdata=32'h2801000A.
REQ-026 Store d_addr=10, d_wdata=32'h55 then load d_addr=10 -> m_we=1 in store ACCESS, d_valid each op, load d_rdata=32'h55.
REQ-027 Both requesting continuously, STARVE_MAX=2 -> grant order D,D,F,D,D,F; no fetch lost.
REQ-028 MEM_LAT=3, load -> d_valid in cycle 5 only, data equals memory contents.
REQ-029 rst asserted in WAIT -> outputs zero same cycle, no valid, next request served normally from IDLE.
REQ-030 ARB_PERF_EN, both requests held 10 arbitrations -> conflict_cnt equals count of IDLE cycles with both high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbitration onto one single-port synchronous memory; define ARB_PERF_EN to add conflict_cnt
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
`ifdef ARB_PERF_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic own_d, we_q, start, pick_d, last_wait;
  logic [3:0] starve, wcnt;
  assign start     = state == IDLE && (if_req || d_req);
  assign pick_d    = d_req && !(if_req && starve == 4'(STARVE_MAX));
  assign last_wait = state == WAIT && wcnt == 4'(MEM_LAT - 1);
  // state register
  always_ff @(posedge clk1 or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state and memory/handshake outputs; only ACCESS touches the memory
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ACCESS : IDLE;
      ACCESS:  state_nx = WAIT;
      WAIT:    state_nx = last_wait ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
    m_en     = state == ACCESS;
    m_we     = state == ACCESS && we_q;
    if_gnt   = state == ACCESS && !own_d;
    d_gnt    = state == ACCESS && own_d;
    if_valid = state == RESP && !own_d;
    d_valid  = state == RESP && own_d;
    busy     = state != IDLE;
  end
  // latch the winning request and track how long fetch has been passed over
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      own_d   <= 1'b0;
      we_q    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      starve  <= '0;
    end else if (start) begin
      own_d   <= pick_d;
      we_q    <= pick_d && d_we;
      m_addr  <= pick_d ? d_addr : if_addr;
      m_wdata <= pick_d ? d_wdata : '0;
      starve  <= !pick_d ? '0 : (if_req && starve != 4'(STARVE_MAX)) ? starve + 4'd1 : starve;
    end
  // memory latency counter, restarted on every WAIT entry
  always_ff @(posedge clk1 or posedge rst)
    if (rst) wcnt <= '0;
    else wcnt <= state == WAIT ? wcnt + 4'd1 : '0;
  // capture read data for the owner; stores leave d_rdata untouched
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (last_wait) begin
      if (!own_d) if_rdata <= m_rdata;
      if (own_d && !we_q) d_rdata <= m_rdata;
    end
`ifdef ARB_PERF_EN
  // saturating count of idle cycles where both requesters compete
  always_ff @(posedge clk1 or posedge rst)
    if (rst) conflict_cnt <= '0;
    else if (state == IDLE && if_req && d_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level model check of mem_port_arbiter with directed and random traffic
module tb_mem_port_arbiter;
  localparam int AW = 10, DW = 32, LAT = 1, SMAX = 2;
  logic clk1 = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic if_gnt, if_valid, d_gnt, d_valid, m_en, m_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
  logic d3_req = 1'b0;
  logic [AW-1:0] d3_addr = '0, ma3;
  logic [DW-1:0] ifr3, dr3, mw3, mr3;
  logic g3a, g3b, v3a, v3b, e3, w3, b3;
`ifdef ARB_PERF_EN
  logic [15:0] conflict_cnt, cc3;
`endif
  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk1(clk1), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_valid(d_valid), .d_rdata(d_rdata), .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
`ifdef ARB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );
  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut3 (
    .clk1(clk1), .rst(rst), .if_req(1'b0), .if_addr('0), .if_gnt(g3a), .if_valid(v3a),
    .if_rdata(ifr3), .d_req(d3_req), .d_we(1'b0), .d_addr(d3_addr), .d_wdata('0), .d_gnt(g3b),
    .d_valid(v3b), .d_rdata(dr3), .m_en(e3), .m_we(w3), .m_addr(ma3), .m_wdata(mw3),
    .m_rdata(mr3), .busy(b3)
`ifdef ARB_PERF_EN
    , .conflict_cnt(cc3)
`endif
  );
  always #5 clk1 = ~clk1;
  // memory contents: a fixed pattern until written; Mem[5] = 32'h2801000A
  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return 32'h2801000A + (32'(a) - 32'd5) * 32'h9E3779B1;
  endfunction
  logic [DW-1:0] mem [1024];
  bit mv [1024];
  logic [DW-1:0] pipe [LAT];
  logic [DW-1:0] p3 [3];
  function automatic logic [DW-1:0] mrd(logic [AW-1:0] a);
    return mv[a] ? mem[a] : init_val(a);
  endfunction
  always @(posedge clk1) begin
    if (m_en && m_we) begin
      mem[m_addr] <= m_wdata;
      mv[m_addr] <= 1'b1;
    end
    if (m_en) pipe[0] <= mrd(m_addr);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (e3) p3[0] <= mrd(ma3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign m_rdata = pipe[LAT-1];
  assign mr3 = p3[2];
  // reference model: one transaction at a time, scheduled by cycle numbers
  logic [DW-1:0] ref_mem [1024];
  bit rv [1024];
  int cyc = 0, gnt_c = -10, val_c = -10, free_c = 0, starve = 0, conf = 0;
  bit own_d = 0, own_we = 0, auto_mode = 0, hold_mode = 0;
  logic [AW-1:0] own_a = '0;
  logic [DW-1:0] own_wd = '0, e_if = '0, e_d = '0;
  int if_gnt_c = -100, if_val_c = -100, d_val_n = 0, st_we_seen = 0, gn = 0;
  logic [15:0] glog = '0;
  int errs = 0, checks = 0;
  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return rv[a] ? ref_mem[a] : init_val(a);
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic arbitrate();
    if (cyc >= free_c && if_req && d_req && conf < 65535) conf++;
    if (cyc >= free_c && (if_req || d_req)) begin
      own_d  = d_req && !(if_req && starve == SMAX);
      own_we = own_d && d_we;
      own_a  = own_d ? d_addr : if_addr;
      own_wd = d_wdata;
      gnt_c  = cyc + 1;
      val_c  = cyc + 2 + LAT;
      free_c = cyc + 3 + LAT;
      if (!own_d) starve = 0;
      else if (if_req && starve < SMAX) starve++;
      if (own_we) begin
        ref_mem[own_a] = own_wd;
        rv[own_a] = 1'b1;
      end
    end
  endtask
  task automatic step();
    logic eg, ev;
    arbitrate();
    @(posedge clk1);
    cyc++;
    @(negedge clk1);
    eg = cyc == gnt_c;
    ev = cyc == val_c;
    if (ev && !own_d) e_if = ref_rd(own_a);
    if (ev && own_d && !own_we) e_d = ref_rd(own_a);
    chk("ctrl{ig,dg,iv,dv,en,we,busy}", {if_gnt, d_gnt, if_valid, d_valid, m_en, m_we, busy},
        {eg && !own_d, eg && own_d, ev && !own_d, ev && own_d, eg, eg && own_we, cyc >= gnt_c && cyc <= val_c});
    chk("if_rdata", if_rdata, e_if);
    chk("d_rdata", d_rdata, e_d);
    if (eg) chk("m_addr", m_addr, own_a);
    if (eg && own_we) chk("m_wdata", m_wdata, own_wd);
`ifdef ARB_PERF_EN
    chk("conflict_cnt", conflict_cnt, conf);
`endif
    if (if_gnt) begin glog = {glog[14:0], 1'b0}; gn++; if_gnt_c = cyc; end
    if (d_gnt) begin glog = {glog[14:0], 1'b1}; gn++; if (m_we) st_we_seen++; end
    if (if_valid) if_val_c = cyc;
    if (d_valid) d_val_n++;
    if (ev && !hold_mode) begin
      if (own_d) d_req = 1'b0;
      else if_req = 1'b0;
    end
    if (auto_mode && !if_req && $urandom_range(3) != 0) begin
      if_req = 1'b1;
      if_addr = AW'($urandom_range(15));
    end
    if (auto_mode && !d_req && $urandom_range(3) != 0) begin
      d_req = 1'b1;
      d_we = 1'($urandom_range(1));
      d_addr = AW'($urandom_range(15));
      d_wdata = $urandom;
    end
  endtask
  task automatic drain(int lim);
    int n = 0;
    while ((if_req || d_req) && n < lim) begin
      step();
      n++;
    end
    if (if_req || d_req) begin
      checks++;
      errs++;
      $display("FAIL drain_timeout: requests pending after %0d cycles, required none", lim);
    end
    step();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end
  initial begin
    int t0, n, vc, nv;
    logic [5:0] g6;
    @(negedge clk1);
    chk("rst_ctrl", {if_gnt, d_gnt, if_valid, d_valid, m_en, m_we, busy}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    chk("rst_maddr_wdata", {m_addr, m_wdata}, 0);
    rst = 1'b0;
    step();
    // fetch only from Mem[5]
    t0 = cyc;
    if_addr = 10'd5;
    if_req = 1'b1;
    drain(20);
    chk("fetch_gnt_latency", if_gnt_c - t0, 1);
    chk("fetch_valid_latency", if_val_c - t0, 3);
    chk("fetch_rdata_literal", if_rdata, 32'h2801000A);
    // store 0x55 to 10 then load it back
    d_we = 1'b1; d_addr = 10'd10; d_wdata = 32'h55; d_req = 1'b1;
    drain(20);
    d_we = 1'b0; d_req = 1'b1;
    drain(20);
    chk("store_m_we_seen", st_we_seen, 1);
    chk("store_load_valids", d_val_n, 2);
    chk("load_rdata_literal", d_rdata, 32'h55);
    chk("fetch_rdata_held", if_rdata, 32'h2801000A);
    // both requesting continuously: D,D,F,D,D,F
    glog = '0; gn = 0; n = 0;
    if_addr = 10'd2; d_addr = 10'd10; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1; hold_mode = 1'b1;
    while (gn < 6 && n < 60) begin step(); n++; end
    g6 = glog[5:0];
    hold_mode = 1'b0;
    chk("grant_order_DDFDDF", g6, 6'b110110);
    drain(40);
    // reset during WAIT of a load
    t0 = cyc;
    d_addr = 10'd3; d_we = 1'b0; d_req = 1'b1;
    step(); step();
    chk("in_wait_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_wait_ctrl", {if_gnt, d_gnt, if_valid, d_valid, m_en, m_we, busy}, 0);
    chk("rst_wait_rdata", {if_rdata, d_rdata}, 0);
    chk("rst_wait_maddr", m_addr, 0);
    gnt_c = -10; val_c = -10; starve = 0; conf = 0; e_if = '0; e_d = '0;
    if_req = 1'b0; d_req = 1'b0;
    nv = d_val_n;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("rst_no_valid", d_val_n - nv, 0);
    t0 = cyc;
    if_addr = 10'd5; if_req = 1'b1;
    drain(20);
    chk("post_rst_fetch_latency", if_val_c - t0, 3);
    chk("post_rst_fetch_rdata", if_rdata, 32'h2801000A);
    // random traffic against the model
    auto_mode = 1'b1;
    repeat (500) step();
    auto_mode = 1'b0;
    drain(40);
    // MEM_LAT=3 instance: single load from address 7
    t0 = cyc; vc = -1; nv = 0;
    d3_addr = 10'd7; d3_req = 1'b1;
    repeat (10) begin
      @(posedge clk1);
      cyc++;
      @(negedge clk1);
      if (v3b) begin
        nv++;
        if (vc < 0) vc = cyc;
        d3_req = 1'b0;
      end
    end
    chk("lat3_valid_count", nv, 1);
    chk("lat3_valid_cycle", vc - t0, 5);
    chk("lat3_rdata", dr3, ref_rd(10'd7));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
